// File: rtl/music_seq_player.sv
// Song sequencer: walks 5-bit note codes from an external synchronous ROM and
// renders each one as a square-wave beep for one tempo-scaled beat.
module music_seq_player #(
  parameter int CLK_HZ   = 25000000,
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 256,
  parameter int BEAT_CYC = 6250000
) (
  input  logic              ext_clk_25m,
  input  logic              ext_rst,
  input  logic              play,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        note_code,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              done,
  output logic              beep,
  output logic [2:0]        dbg_state
);

  // Longest half period belongs to C4 (262 Hz): CLK_HZ / 524.
  localparam int HP_W   = $clog2(CLK_HZ / 524 + 1);
  localparam int BEAT_W = $clog2(BEAT_CYC + 1);

  localparam logic [4:0]        END_CODE  = 5'd31;
  localparam logic [4:0]        TOP_TONE  = 5'd21;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [HP_W-1:0]   HP_ONE    = HP_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BEAT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_PLAY, S_PAUSE, S_END, S_DONE
  } state_t;

  function automatic int hp_calc(input int code);
    int f;
    if (code < 1 || code > 21) return 0;
    case ((code - 1) % 7)
      0:       f = 262;
      1:       f = 294;
      2:       f = 330;
      3:       f = 349;
      4:       f = 392;
      5:       f = 440;
      default: f = 494;
    endcase
    f = f << ((code - 1) / 7);
    return CLK_HZ / (2 * f);
  endfunction

  logic [HP_W-1:0] hp_tab [32];
  for (genvar g = 0; g < 32; g++) begin : g_hp
    localparam int HP_V = hp_calc(g);
    assign hp_tab[g] = HP_W'(HP_V);
  end

  state_t            state, state_d;
  logic [ADDR_W-1:0] rom_addr_d, start_q, start_d, idx_d;
  logic [4:0]        code_d;
  logic [BEAT_W-1:0] beat_len, len_d, beat_cnt, beat_d;
  logic [HP_W-1:0]   tone_cnt, tone_d, hp_cur;
  logic              tone_ph, ph_d, is_tone, beat_last, tone_last;
  logic              busy_d, done_d, beep_d;

  assign is_tone   = (note_code != 5'd0) && (note_code <= TOP_TONE);
  assign hp_cur    = hp_tab[note_code];
  assign beat_last = (beat_cnt + BEAT_ONE) >= beat_len;
  assign tone_last = (tone_cnt + HP_ONE) >= hp_cur;
  assign dbg_state = state;

  always_comb begin
    state_d    = state;
    rom_addr_d = rom_addr;
    start_d    = start_q;
    code_d     = note_code;
    idx_d      = note_idx;
    len_d      = beat_len;
    beat_d     = beat_cnt;
    tone_d     = tone_cnt;
    ph_d       = tone_ph;
    case (state)
      S_IDLE: begin
        if (play) begin
          rom_addr_d = start_addr;
          start_d    = start_addr;
          state_d    = S_FETCH1;
        end
      end
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: begin
        if (rom_data == END_CODE) begin
          state_d = S_END;
        end else begin
          code_d  = rom_data;
          idx_d   = rom_addr;
          len_d   = BEAT_FULL >> tempo_sel;
          beat_d  = '0;
          tone_d  = '0;
          ph_d    = 1'b0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // A paused cycle is not counted, so a note ending and a pause
        // arriving together leaves the final beat cycle for the resume.
        if (!play) begin
          state_d = S_PAUSE;
        end else begin
          if (is_tone) begin
            if (tone_last) begin
              tone_d = '0;
              ph_d   = ~tone_ph;
            end else begin
              tone_d = tone_cnt + HP_ONE;
            end
          end
          if (beat_last) begin
            if (rom_addr == LAST_ADDR) begin
              state_d = S_END;
            end else begin
              rom_addr_d = rom_addr + ADDR_ONE;
              state_d    = S_FETCH1;
            end
          end else begin
            beat_d = beat_cnt + BEAT_ONE;
          end
        end
      end
      S_PAUSE: if (play) state_d = S_PLAY;
      S_END: begin
        if (loop_en) begin
          rom_addr_d = start_q;
          state_d    = S_FETCH1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (!play) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The tone phase survives a pause; only the beep pin is forced low.
  assign beep_d = (state_d == S_PLAY) && is_tone && ph_d;
  assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  assign done_d = (state_d == S_DONE) && (state != S_DONE);

  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      start_q   <= '0;
      note_code <= '0;
      note_idx  <= '0;
      beat_len  <= '0;
      beat_cnt  <= '0;
      tone_cnt  <= '0;
      tone_ph   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      beep      <= 1'b0;
    end else begin
      state     <= state_d;
      rom_addr  <= rom_addr_d;
      start_q   <= start_d;
      note_code <= code_d;
      note_idx  <= idx_d;
      beat_len  <= len_d;
      beat_cnt  <= beat_d;
      tone_cnt  <= tone_d;
      tone_ph   <= ph_d;
      busy      <= busy_d;
      done      <= done_d;
      beep      <= beep_d;
    end
  end

endmodule

// File: tb/tb_music_seq_player.sv
// Bench for music_seq_player: a note-level model predicts every output each
// cycle, and directed songs pin tone counts, latencies and note order.
module tb_music_seq_player;

  localparam int CLK_HZ   = 26200;
  localparam int ADDR_W   = 3;
  localparam int SONG_LEN = 8;
  localparam int BEAT_CYC = 400;
  localparam int VEC_W    = 2 * ADDR_W + 8;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_SOUND = 2;
  localparam int M_HOLD  = 3;
  localparam int M_END   = 4;
  localparam int M_DONE  = 5;

  // clock / reset
  logic clk = 1'b0;
  logic ext_rst = 1'b1;
  always #5 clk = ~clk;

  logic              play = 1'b0;
  logic              loop_en = 1'b0;
  logic [1:0]        tempo_sel = 2'd0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [4:0]        rom_data = 5'd0;
  logic [4:0]        note_code;
  logic [ADDR_W-1:0] note_idx;
  logic              busy, done, beep;
  logic [2:0]        dbg_state;

  logic [4:0] rom [SONG_LEN];
  always @(posedge clk) rom_data <= rom[rom_addr];

  music_seq_player #(
    .CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .SONG_LEN(SONG_LEN), .BEAT_CYC(BEAT_CYC)
  ) dut (
    .ext_clk_25m(clk), .ext_rst(ext_rst), .play(play), .loop_en(loop_en),
    .tempo_sel(tempo_sel), .start_addr(start_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .note_code(note_code), .note_idx(note_idx),
    .busy(busy), .done(done), .beep(beep), .dbg_state(dbg_state)
  );

  // model: where the song is, and how many beat cycles of the note have sounded
  int   m_mode, m_fetch_left, m_addr, m_start, m_code, m_idx, m_len, m_elapsed;
  logic m_pulse;

  // scoreboard / monitor
  logic [VEC_W-1:0] exp_q[$];
  logic [7:0]       seen_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rises = 0;
  int   highs = 0;
  int   dones = 0;
  logic beep_prev = 1'b0;
  logic [4:0] last_code = 5'd0;
  logic [ADDR_W-1:0] last_idx = '0;

  function automatic int note_hp(input int code);
    int f;
    case ((code - 1) % 7)
      0:       f = 262;
      1:       f = 294;
      2:       f = 330;
      3:       f = 349;
      4:       f = 392;
      5:       f = 440;
      default: f = 494;
    endcase
    f = f * (1 << ((code - 1) / 7));
    return CLK_HZ / (2 * f);
  endfunction

  function automatic logic [VEC_W-1:0] model_vec();
    logic b, bp;
    b  = (m_mode != M_IDLE) && (m_mode != M_DONE);
    bp = 1'b0;
    if (m_mode == M_SOUND && m_code >= 1 && m_code <= 21)
      bp = ((m_elapsed / note_hp(m_code)) % 2) == 1;
    return {ADDR_W'(m_addr), 5'(m_code), ADDR_W'(m_idx), b, m_pulse, bp};
  endfunction

  task automatic model_step();
    if (ext_rst) begin
      m_mode = M_IDLE; m_fetch_left = 0; m_addr = 0; m_start = 0;
      m_code = 0; m_idx = 0; m_len = 0; m_elapsed = 0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      case (m_mode)
        M_IDLE: if (play) begin
          m_addr = int'(start_addr); m_start = int'(start_addr);
          m_mode = M_FETCH; m_fetch_left = 2;
        end
        M_FETCH: begin
          m_fetch_left--;
          if (m_fetch_left == 0) begin
            if (rom[m_addr] == 5'd31) m_mode = M_END;
            else begin
              m_code = int'(rom[m_addr]); m_idx = m_addr;
              m_len = BEAT_CYC / (1 << tempo_sel); m_elapsed = 0;
              m_mode = M_SOUND;
            end
          end
        end
        M_SOUND: if (!play) m_mode = M_HOLD;
        else begin
          m_elapsed++;
          if (m_elapsed == m_len) begin
            if (m_addr == SONG_LEN - 1) m_mode = M_END;
            else begin m_addr++; m_mode = M_FETCH; m_fetch_left = 2; end
          end
        end
        M_HOLD: if (play) m_mode = M_SOUND;
        M_END: if (loop_en) begin
          m_addr = m_start; m_mode = M_FETCH; m_fetch_left = 2;
        end else begin
          m_mode = M_DONE; m_pulse = 1'b1;
        end
        M_DONE: if (!play) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    logic [VEC_W-1:0] exp_v, act_v;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_vec());
    @(negedge clk);
    exp_v = exp_q.pop_front();
    act_v = {rom_addr, note_code, note_idx, busy, done, beep};
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL cycle t=%0t state=%0d actual=%h required=%h", $time, dbg_state, act_v, exp_v);
    end
    if (beep && !beep_prev) rises++;
    if (beep) highs++;
    if (done) dones++;
    beep_prev = beep;
    if (note_code != 5'd0 && (note_code != last_code || note_idx != last_idx))
      seen_q.push_back({note_idx, note_code});
    last_code = note_code;
    last_idx  = note_idx;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_done(input int budget, output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (done !== 1'b1 && ticks < budget);
    check("done_seen", int'(done), 1);
  endtask

  task automatic fill_rom(input logic [4:0] v);
    for (int i = 0; i < SONG_LEN; i++) rom[i] = v;
  endtask

  task automatic stop_song();
    play = 1'b0;
    tick();
    tick();
  endtask

  task automatic seen_entry(input string name, input int k, input int idx, input int code);
    logic [7:0] e;
    e = (k < seen_q.size()) ? seen_q[k] : 8'hff;
    check({name, "_idx"}, int'(e[7:5]), idx);
    check({name, "_code"}, int'(e[4:0]), code);
  endtask

  initial begin
    int t, r0, h0, d0, s0;
    int pitch_codes[3];
    int loop_idx[7];
    pitch_codes = '{6, 13, 20};
    loop_idx    = '{2, 3, 4, 5, 6, 7, 2};
    fill_rom(5'd31);

    // reset
    ext_rst = 1'b1;
    repeat (3) tick();
    ext_rst = 1'b0;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_note_code", int'(note_code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_beep", int'(beep), 0);

    // C4 for one beat, then end marker
    rom[0] = 5'd1;
    r0 = rises; h0 = highs; d0 = dones;
    play = 1'b1;
    wait_done(1000, t);
    check("tone_latency", t, 406);
    check("tone_rises", rises - r0, 4);
    check("tone_highs", highs - h0, 200);
    check("tone_done_pulses", dones - d0, 1);
    check("tone_beep_at_done", int'(beep), 0);
    stop_song();

    // pitch table A4 / A5 / A6-ish (code 20)
    fill_rom(5'd31);
    rom[0] = 5'd6; rom[1] = 5'd13; rom[2] = 5'd20;
    r0 = rises; s0 = seen_q.size();
    play = 1'b1;
    wait_done(2000, t);
    check("pitch_latency", t, 1210);
    check("pitch_rises", rises - r0, 50);
    check("pitch_notes", seen_q.size() - s0, 3);
    for (int i = 0; i < 3; i++) seen_entry("pitch_note", s0 + i, i, pitch_codes[i]);
    stop_song();

    // tempo_sel=2: rest then C4, 100 cycles each
    fill_rom(5'd31);
    rom[0] = 5'd0; rom[1] = 5'd1;
    tempo_sel = 2'd2;
    r0 = rises; h0 = highs;
    play = 1'b1;
    wait_done(1000, t);
    check("tempo_latency", t, 208);
    check("tempo_rises", rises - r0, 1);
    check("tempo_highs", highs - h0, 50);
    stop_song();

    // pause at beat cycle 150 for 1000 cycles
    fill_rom(5'd31);
    rom[0] = 5'd1;
    tempo_sel = 2'd0;
    play = 1'b1;
    repeat (153) tick();
    check("pre_pause_beep", int'(beep), 1);
    play = 1'b0;
    h0 = highs;
    repeat (1001) tick();
    check("pause_highs", highs - h0, 0);
    check("pause_busy", int'(busy), 1);
    play = 1'b1;
    h0 = highs;
    tick();
    check("resume_phase", int'(beep), 1);
    wait_done(600, t);
    check("resume_remaining", t, 253);
    check("resume_highs", highs - h0, 150);
    stop_song();

    // loop from address 2 over a marker-free ROM, then release the loop
    for (int i = 0; i < SONG_LEN; i++) rom[i] = 5'(i + 3);
    loop_en = 1'b1; start_addr = 3'd2; tempo_sel = 2'd3;
    d0 = dones; s0 = seen_q.size();
    play = 1'b1;
    repeat (650) tick();
    check("loop_no_done", dones - d0, 0);
    check("loop_notes", seen_q.size() - s0, 13);
    for (int i = 0; i < 7; i++) seen_entry("loop_note", s0 + i, loop_idx[i], loop_idx[i] + 3);
    loop_en = 1'b0;
    wait_done(1000, t);
    check("loop_exit_latency", t, 290);
    check("loop_total_notes", seen_q.size() - s0, 18);
    seen_entry("loop_last", seen_q.size() - 1, 7, 10);
    stop_song();

    // reset in the middle of a note with play held
    start_addr = 3'd1; tempo_sel = 2'd0;
    play = 1'b1;
    repeat (100) tick();
    check("pre_reset_busy", int'(busy), 1);
    ext_rst = 1'b1;
    tick();
    ext_rst = 1'b0;
    check("mid_rst_rom_addr", int'(rom_addr), 0);
    check("mid_rst_note_code", int'(note_code), 0);
    check("mid_rst_note_idx", int'(note_idx), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_beep", int'(beep), 0);
    tick();
    check("restart_rom_addr", int'(rom_addr), 1);
    check("restart_busy", int'(busy), 1);
    repeat (60) tick();
    play = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
